// File: rtl/atax_seq_pkg.sv
// Shared types for the atax call sequencer: FSM states and the queued job descriptor.
package atax_seq_pkg;

    localparam int ARG_W     = 64;
    // Queued tags are stored at this width; the top keeps only its TAG_W low bits.
    localparam int TAG_MAX_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_t;

    typedef struct packed {
        logic [ARG_W-1:0]     a;
        logic [ARG_W-1:0]     x;
        logic [ARG_W-1:0]     y_out;
        logic [TAG_MAX_W-1:0] tag;
    } job_t;

endpackage

// File: rtl/atax_job_fifo.sv
// Synchronous job descriptor FIFO; head is the oldest entry, valid whenever !empty.
module atax_job_fifo
    import atax_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  job_t din,
    output job_t head,
    output logic full,
    output logic empty
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    job_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/atax_call_sequencer.sv
// Launches queued atax calls one at a time, collects returns into a single-entry
// completion register, and latches a sticky fault when a call hangs.
module atax_call_sequencer
    import atax_seq_pkg::*;
#(
    parameter int JOB_DEPTH      = 4,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [63:0]       job_a,
    input  logic [63:0]       job_x,
    input  logic [63:0]       job_y_out,
    input  logic [TAG_W-1:0]  job_tag,
    output logic              comp_start,
    input  logic              comp_busy,
    output logic [63:0]       comp_A,
    output logic [63:0]       comp_x,
    output logic [63:0]       comp_y_out,
    input  logic              comp_done,
    output logic              comp_stall,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [TAG_W-1:0]  cpl_tag,
    output logic              cpl_timeout,
    output logic              fault,
    output logic              idle,
    output logic [31:0]       jobs_done
);
    localparam int            WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    job_t             fifo_din;
    job_t             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             call_acc;
    logic             ret_acc;
    logic             wd_sat;
    logic             to_fire;
    logic             load_head;
    logic [TAG_W-1:0] cur_tag;
    logic [WD_W-1:0]  wdog;
    logic             unused_tag_hi;

    always_comb begin
        fifo_din       = '0;
        fifo_din.a     = job_a;
        fifo_din.x     = job_x;
        fifo_din.y_out = job_y_out;
        fifo_din.tag   = TAG_MAX_W'(job_tag);
    end

    assign job_ready  = !fifo_full && !fault;
    assign push       = job_valid && job_ready;
    // After a fault the late done pulses are swallowed, so never stall them.
    assign comp_stall = cpl_valid && !cpl_ready && !fault;
    assign call_acc   = (state == ISSUE) && !comp_busy;
    assign ret_acc    = (state == WAIT) && comp_done && !comp_stall;
    assign wd_sat     = (wdog == WD_MAX);
    assign to_fire    = (state == WAIT) && !ret_acc && wd_sat && (!cpl_valid || cpl_ready);
    assign load_head  = !fifo_empty && ((state == IDLE) || ret_acc);
    assign unused_tag_hi = ^fifo_head.tag;

    atax_job_fifo #(.DEPTH(JOB_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (call_acc),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            comp_start  <= 1'b0;
            comp_A      <= '0;
            comp_x      <= '0;
            comp_y_out  <= '0;
            cur_tag     <= '0;
            cpl_valid   <= 1'b0;
            cpl_tag     <= '0;
            cpl_timeout <= 1'b0;
            fault       <= 1'b0;
            idle        <= 1'b1;
            jobs_done   <= '0;
            wdog        <= '0;
        end else begin
            idle <= (state == IDLE) && fifo_empty && !push && !(cpl_valid && !cpl_ready);
            if (cpl_valid && cpl_ready) cpl_valid <= 1'b0;
            if (state == WAIT && !ret_acc && !wd_sat) wdog <= wdog + 1'b1;
            if (load_head) begin
                comp_A     <= fifo_head.a;
                comp_x     <= fifo_head.x;
                comp_y_out <= fifo_head.y_out;
                cur_tag    <= fifo_head.tag[TAG_W-1:0];
            end
            case (state)
                IDLE: if (!fifo_empty) begin
                    comp_start <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: if (!comp_busy) begin
                    comp_start <= 1'b0;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: if (ret_acc) begin
                    cpl_valid   <= 1'b1;
                    cpl_tag     <= cur_tag;
                    cpl_timeout <= 1'b0;
                    jobs_done   <= jobs_done + 32'd1;
                    comp_start  <= !fifo_empty;
                    state       <= fifo_empty ? IDLE : ISSUE;
                end else if (to_fire) begin
                    cpl_valid   <= 1'b1;
                    cpl_tag     <= cur_tag;
                    cpl_timeout <= 1'b1;
                    fault       <= 1'b1;
                    state       <= FAULT;
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
